// File: rtl/rr_enc_pkg.sv
// Shared sizes, types and helpers for the round-robin 8:3 encoder.
package rr_enc_pkg;
  localparam int N = 8;
  localparam int W = 3;

  typedef logic [N-1:0] req_t;
  typedef logic [W-1:0] idx_t;

  function automatic req_t onehot(input idx_t i);
    req_t r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction
endpackage

// File: rtl/rr_first_set.sv
// Combinational circular search: first set request bit at or after start.
module rr_first_set
  import rr_enc_pkg::*;
(
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic [W-1:0] sel,
  output logic         any
);
  req_t rot;
  idx_t off;

  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++) begin
      rot[i] = req[idx_t'(start + idx_t'(i))];
    end
  end

  // Descending scan so the lowest set bit of the rotated vector wins.
  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = idx_t'(i);
    end
  end

  assign sel = idx_t'(start + off);
  assign any = |req;
endmodule

// File: rtl/rr_encoder8_3.sv
// Registered round-robin priority encoder with valid/ready output handshake.
module rr_encoder8_3
  import rr_enc_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] idx,
  output logic [N-1:0] grant,
  output logic         none
);
  idx_t ptr;
  idx_t idx_inc;
  idx_t start;
  idx_t sel;
  logic any;
  logic accept;
  logic free;

  assign accept  = out_valid & out_ready;
  assign free    = ~out_valid | out_ready;
  assign idx_inc = idx_t'(idx + 1'b1);
  // The consumer taking idx this cycle demotes it to lowest priority now.
  assign start   = accept ? idx_inc : ptr;

  rr_first_set u_first_set (
    .req   (req),
    .start (start),
    .sel   (sel),
    .any   (any)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr       <= '0;
      out_valid <= 1'b0;
      idx       <= '0;
      grant     <= '0;
      none      <= 1'b1;
    end else begin
      if (accept) ptr <= idx_inc;
      if (free && en) begin
        if (any) begin
          idx       <= sel;
          grant     <= onehot(sel);
          out_valid <= 1'b1;
          none      <= 1'b0;
        end else begin
          out_valid <= 1'b0;
          grant     <= '0;
          none      <= 1'b1;
        end
      end else if (accept) begin
        out_valid <= 1'b0;
        grant     <= '0;
      end
    end
  end
endmodule

// File: tb/tb_rr_encoder8_3.sv
// Directed vector table plus hand sequences for the round-robin encoder.
module tb_rr_encoder8_3;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] req = 8'h00;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [2:0] idx;
  logic [7:0] grant;
  logic       none;

  int checks = 0;
  int errors = 0;

  rr_encoder8_3 dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .req       (req),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .idx       (idx),
    .grant     (grant),
    .none      (none)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic       rdy;
    logic       ev;
    logic [2:0] ei;
    logic [7:0] eg;
    logic       enone;
  } vec_t;

  vec_t tbl[29];

  function automatic vec_t mk(input logic r, input logic e, input logic [7:0] q,
                              input logic rd, input logic v, input logic [2:0] i,
                              input logic [7:0] g, input logic n);
    vec_t t;
    t.rst_n = r; t.en = e; t.req = q; t.rdy = rd;
    t.ev = v; t.ei = i; t.eg = g; t.enone = n;
    return t;
  endfunction

  task automatic chk(input string name, input int row, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %h want %h", name, row, act, exp);
    end
  endtask

  task automatic step(input vec_t t, input int row);
    @(negedge clk);
    reset_n = t.rst_n; en = t.en; req = t.req; out_ready = t.rdy;
    @(posedge clk);
    #1;
    chk("out_valid", row, {7'd0, out_valid}, {7'd0, t.ev});
    chk("idx",       row, {5'd0, idx},       {5'd0, t.ei});
    chk("grant",     row, grant,             t.eg);
    chk("none",      row, {7'd0, none},      {7'd0, t.enone});
  endtask

  initial begin
    //                rst en req    rdy  v  idx  grant  none
    tbl[0]  = mk(1'b0, 1, 8'hFF, 1, 0, 3'd0, 8'h00, 1);  // reset held
    tbl[1]  = mk(1'b0, 1, 8'hFF, 1, 0, 3'd0, 8'h00, 1);
    tbl[2]  = mk(1'b1, 1, 8'hFF, 1, 1, 3'd0, 8'h01, 0);  // rotation
    tbl[3]  = mk(1'b1, 1, 8'hFF, 1, 1, 3'd1, 8'h02, 0);
    tbl[4]  = mk(1'b1, 1, 8'hFF, 1, 1, 3'd2, 8'h04, 0);
    tbl[5]  = mk(1'b1, 1, 8'hFF, 1, 1, 3'd3, 8'h08, 0);
    tbl[6]  = mk(1'b1, 1, 8'hFF, 1, 1, 3'd4, 8'h10, 0);
    tbl[7]  = mk(1'b1, 1, 8'hFF, 1, 1, 3'd5, 8'h20, 0);
    tbl[8]  = mk(1'b1, 1, 8'hFF, 1, 1, 3'd6, 8'h40, 0);
    tbl[9]  = mk(1'b1, 1, 8'hFF, 1, 1, 3'd7, 8'h80, 0);
    tbl[10] = mk(1'b1, 1, 8'hFF, 1, 1, 3'd0, 8'h01, 0);
    tbl[11] = mk(1'b1, 1, 8'hFF, 1, 1, 3'd1, 8'h02, 0);
    tbl[12] = mk(1'b1, 1, 8'h24, 1, 1, 3'd2, 8'h04, 0);  // backpressure
    tbl[13] = mk(1'b1, 1, 8'h24, 0, 1, 3'd2, 8'h04, 0);
    tbl[14] = mk(1'b1, 1, 8'h01, 0, 1, 3'd2, 8'h04, 0);
    tbl[15] = mk(1'b1, 1, 8'h01, 0, 1, 3'd2, 8'h04, 0);
    tbl[16] = mk(1'b1, 1, 8'h01, 1, 1, 3'd0, 8'h01, 0);
    tbl[17] = mk(1'b1, 1, 8'h20, 1, 1, 3'd5, 8'h20, 0);  // wrap and skip
    tbl[18] = mk(1'b1, 1, 8'h03, 1, 1, 3'd0, 8'h01, 0);
    tbl[19] = mk(1'b1, 1, 8'h03, 1, 1, 3'd1, 8'h02, 0);
    tbl[20] = mk(1'b1, 1, 8'h03, 1, 1, 3'd0, 8'h01, 0);
    tbl[21] = mk(1'b1, 1, 8'h00, 1, 0, 3'd0, 8'h00, 1);  // empty, enable
    tbl[22] = mk(1'b1, 0, 8'h80, 1, 0, 3'd0, 8'h00, 1);
    tbl[23] = mk(1'b1, 1, 8'h80, 1, 1, 3'd7, 8'h80, 0);
    tbl[24] = mk(1'b1, 0, 8'hFF, 1, 0, 3'd7, 8'h00, 0);  // accept without load
    tbl[25] = mk(1'b1, 1, 8'hFF, 0, 1, 3'd0, 8'h01, 0);
    tbl[26] = mk(1'b1, 1, 8'hFF, 0, 1, 3'd0, 8'h01, 0);
    tbl[27] = mk(1'b1, 1, 8'h08, 1, 1, 3'd3, 8'h08, 0);  // single requester
    tbl[28] = mk(1'b1, 1, 8'h08, 1, 1, 3'd3, 8'h08, 0);

    for (int k = 0; k < 29; k++) step(tbl[k], k);

    // Reset in the middle of a stalled handshake; ptr is 4 beforehand.
    step(mk(1'b1, 1, 8'h10, 1, 1, 3'd4, 8'h10, 0), 100);
    step(mk(1'b1, 1, 8'h10, 0, 1, 3'd4, 8'h10, 0), 101);
    step(mk(1'b0, 1, 8'h10, 0, 0, 3'd0, 8'h00, 1), 102);
    step(mk(1'b1, 1, 8'h11, 0, 1, 3'd0, 8'h01, 0), 103);
    step(mk(1'b1, 1, 8'h11, 1, 1, 3'd4, 8'h10, 0), 104);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
